// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - I2C register-pointer target with oversampled SCL/SDA and open-drain SDA
// Optional I2C_TARGET_FILTER_EN adds a 3-sample majority filter on both synchronized lines.
module i2c_target #(
  parameter logic [6:0]  TARGET_ADDR = 7'h50,
  parameter int unsigned ADDR_W      = 4
) (
  input  logic              clk_4MHz,
  input  logic              rst_n,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_oe,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  input  logic [7:0]        reg_rdata,
  output logic              busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, WACK, WDATA, RDATA, RACK, IGNORE
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        scl_sync_q, sda_sync_q;
  logic              scl_f, sda_f;
  logic              scl_prev_q, sda_prev_q;
  logic              rise, fall, start_c, stop_c;
  logic [3:0]        cnt_q, cnt_d;
  logic [7:0]        shift_q, shift_d, byte_in;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              oe_q, oe_d, we_q, we_d, busy_q, busy_d, rw_q, rw_d;
  logic [7:0]        wdata_q, wdata_d;

  // Idle bus is high, so synchronizers reset to 1 to avoid a false edge after reset.
  always_ff @(posedge clk_4MHz or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
    end
  end

`ifdef I2C_TARGET_FILTER_EN
  logic [1:0] scl_hist_q, sda_hist_q;
  logic       scl_maj_q, sda_maj_q;

  always_ff @(posedge clk_4MHz or negedge rst_n) begin
    if (!rst_n) begin
      scl_hist_q <= 2'b11;
      sda_hist_q <= 2'b11;
      scl_maj_q  <= 1'b1;
      sda_maj_q  <= 1'b1;
    end else begin
      scl_hist_q <= {scl_hist_q[0], scl_sync_q[1]};
      sda_hist_q <= {sda_hist_q[0], sda_sync_q[1]};
      scl_maj_q  <= (scl_sync_q[1] & scl_hist_q[0]) | (scl_sync_q[1] & scl_hist_q[1]) |
                    (scl_hist_q[0] & scl_hist_q[1]);
      sda_maj_q  <= (sda_sync_q[1] & sda_hist_q[0]) | (sda_sync_q[1] & sda_hist_q[1]) |
                    (sda_hist_q[0] & sda_hist_q[1]);
    end
  end

  assign scl_f = scl_maj_q;
  assign sda_f = sda_maj_q;
`else
  assign scl_f = scl_sync_q[1];
  assign sda_f = sda_sync_q[1];
`endif

  assign rise    = scl_f & ~scl_prev_q;
  assign fall    = ~scl_f & scl_prev_q;
  assign start_c = scl_f & scl_prev_q & sda_prev_q & ~sda_f;
  assign stop_c  = scl_f & scl_prev_q & ~sda_prev_q & sda_f;

  always_ff @(posedge clk_4MHz or negedge rst_n) begin
    if (!rst_n) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      shift_q    <= 8'h00;
      ptr_q      <= '0;
      oe_q       <= 1'b0;
      we_q       <= 1'b0;
      wdata_q    <= 8'h00;
      busy_q     <= 1'b0;
      rw_q       <= 1'b0;
    end else begin
      scl_prev_q <= scl_f;
      sda_prev_q <= sda_f;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      oe_q       <= oe_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      rw_q       <= rw_d;
    end
  end

  // ACK states use oe_q as their phase: first fall starts the ACK, second fall ends it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    ptr_d   = ptr_q;
    oe_d    = oe_q;
    we_d    = 1'b0;
    wdata_d = wdata_q;
    busy_d  = busy_q;
    rw_d    = rw_q;
    byte_in = {shift_q[6:0], sda_f};
    if (we_q) ptr_d = ptr_q + ADDR_W'(1);
    if (stop_c) begin
      state_d = IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else if (start_c) begin
      state_d = ADDR;
      cnt_d   = 4'd0;
      oe_d    = 1'b0;
    end else begin
      unique case (state_q)
        ADDR: if (rise) begin
          shift_d = byte_in;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            if (shift_q[6:0] == TARGET_ADDR) begin
              busy_d  = 1'b1;
              rw_d    = sda_f;
              state_d = ADDR_ACK;
            end else begin
              state_d = IGNORE;
            end
          end
        end
        ADDR_ACK: if (fall) begin
          if (!oe_q) begin
            oe_d = 1'b1;
          end else if (rw_q) begin
            oe_d    = ~reg_rdata[7];
            shift_d = {reg_rdata[6:0], 1'b0};
            cnt_d   = 4'd1;
            state_d = RDATA;
          end else begin
            oe_d    = 1'b0;
            cnt_d   = 4'd0;
            state_d = PTR;
          end
        end
        PTR: if (rise) begin
          shift_d = byte_in;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            ptr_d   = byte_in[ADDR_W-1:0];
            state_d = WACK;
          end
        end
        WACK: if (fall) begin
          if (!oe_q) begin
            oe_d = 1'b1;
          end else begin
            oe_d    = 1'b0;
            cnt_d   = 4'd0;
            state_d = WDATA;
          end
        end
        WDATA: if (rise) begin
          shift_d = byte_in;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            we_d    = 1'b1;
            wdata_d = byte_in;
            state_d = WACK;
          end
        end
        RDATA: if (fall) begin
          if (cnt_q == 4'd8) begin
            oe_d    = 1'b0;
            state_d = RACK;
          end else begin
            oe_d    = ~shift_q[7];
            shift_d = {shift_q[6:0], 1'b0};
            cnt_d   = cnt_q + 4'd1;
          end
        end
        // Entered on a fall, so the next fall always follows the master's ACK rise.
        RACK: if (rise) begin
          if (sda_f) state_d = IGNORE;
          else       ptr_d   = ptr_q + ADDR_W'(1);
        end else if (fall) begin
          oe_d    = ~reg_rdata[7];
          shift_d = {reg_rdata[6:0], 1'b0};
          cnt_d   = 4'd1;
          state_d = RDATA;
        end
        default: ;
      endcase
    end
  end

  assign sda_oe    = oe_q;
  assign reg_addr  = ptr_q;
  assign reg_wdata = wdata_q;
  assign reg_we    = we_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// tb/tb_i2c_target.sv - randomized scoreboard bench for i2c_target against a transaction-level model
`timescale 1ns/1ps
module tb_i2c_target;

  localparam int Q = 10;

  typedef struct packed {
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_oe, reg_we, busy;
  logic [3:0] reg_addr;
  logic [7:0] reg_wdata, reg_rdata;
  wire        sda_bus = sda_m & ~sda_oe;

  logic [7:0] env_mem   [16];
  logic [7:0] model_mem [16];
  logic [3:0] model_ptr;
  logic [7:0] wbuf      [4];
  wr_t        exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic       we_prev = 1'b0;

  always #125 clk = ~clk;

  i2c_target #(.TARGET_ADDR(7'h50), .ADDR_W(4)) dut (
    .clk_4MHz (clk),
    .rst_n    (rst_n),
    .scl_i    (scl_m),
    .sda_i    (sda_bus),
    .sda_oe   (sda_oe),
    .reg_addr (reg_addr),
    .reg_wdata(reg_wdata),
    .reg_we   (reg_we),
    .reg_rdata(reg_rdata),
    .busy     (busy)
  );

  assign reg_rdata = env_mem[reg_addr];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) env_mem[i] <= 8'hC0 | 8'(i);
    end else if (reg_we) begin
      env_mem[reg_addr] <= reg_wdata;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    wr_t e;
    if (reg_we) begin
      check("we_width", 32'(we_prev), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_we: got addr %0d data 0x%0h expected no write", reg_addr, reg_wdata);
      end else begin
        e = exp_q.pop_front();
        check("we_addr", 32'(reg_addr), 32'(e.a));
        check("we_data", 32'(reg_wdata), 32'(e.d));
      end
    end
    we_prev <= reg_we;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) model_mem[i] = 8'hC0 | 8'(i);
    model_ptr = 4'd0;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b1; wait_clk(Q);
  endtask

  task automatic send_bit(input logic b, input logic glitch);
    sda_m = b; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    if (glitch) begin
      scl_m = 1'b0; wait_clk(1);
      scl_m = 1'b1;
    end
    wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic recv_bit(output logic b);
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    b = sda_bus;  wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, input int g, output logic ack);
    for (int i = 0; i < 8; i++) send_bit(d[7-i], i == g);
    recv_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d);
    logic b;
    for (int i = 0; i < 8; i++) begin
      recv_bit(b);
      d = {d[6:0], b};
    end
  endtask

  // A write addressed elsewhere must be ignored entirely: every byte NACKed, no strobe.
  task automatic write_txn(input logic [6:0] addr, input logic [7:0] ptr, input int n);
    logic ack;
    logic match;
    wr_t  e;
    match = (addr == 7'h50);
    i2c_start();
    write_byte({addr, 1'b0}, -1, ack);
    check("addr_ack", 32'(ack), 32'(!match));
    check("busy_after_addr", 32'(busy), 32'(match));
    write_byte(ptr, -1, ack);
    check("ptr_ack", 32'(ack), 32'(!match));
    if (match) model_ptr = ptr[3:0];
    for (int i = 0; i < n; i++) begin
      if (match) begin
        e.a = model_ptr;
        e.d = wbuf[i];
        exp_q.push_back(e);
        model_mem[model_ptr] = wbuf[i];
        model_ptr = model_ptr + 4'd1;
      end
      write_byte(wbuf[i], -1, ack);
      check("data_ack", 32'(ack), 32'(!match));
    end
    i2c_stop();
    check("busy_after_stop", 32'(busy), 32'd0);
  endtask

  task automatic read_txn(input logic [7:0] ptr, input int n);
    logic       ack;
    logic [7:0] d;
    i2c_start();
    write_byte(8'hA0, -1, ack);
    check("rd_addrw_ack", 32'(ack), 32'd0);
    write_byte(ptr, -1, ack);
    check("rd_ptr_ack", 32'(ack), 32'd0);
    model_ptr = ptr[3:0];
    i2c_start();
    write_byte(8'hA1, -1, ack);
    check("rd_addrr_ack", 32'(ack), 32'd0);
    for (int i = 0; i < n; i++) begin
      read_byte(d);
      check("rdata", 32'(d), 32'(model_mem[model_ptr]));
      if (i < n - 1) begin
        send_bit(1'b0, 1'b0);
        model_ptr = model_ptr + 4'd1;
      end else begin
        send_bit(1'b1, 1'b0);
      end
    end
    check("nack_release", 32'(sda_oe), 32'd0);
    i2c_stop();
    check("rd_busy_after_stop", 32'(busy), 32'd0);
  endtask

  // Expected byte when one extra rise duplicates bit g (MSB = bit 0).
  function automatic logic [7:0] slip_byte(input logic [7:0] d, input int g);
    logic [7:0] r;
    int         src;
    for (int k = 0; k < 8; k++) begin
      src = (k <= g) ? k : k - 1;
      r[7-k] = d[7-src];
    end
    return r;
  endfunction

  initial begin
    logic       ack;
    logic       seen;
    logic [7:0] exp_d;
    logic       exp_ack;
    logic [6:0] ra;
    wr_t        e;

    model_reset();
    wait_clk(4);
    check("rst_sda_oe", 32'(sda_oe), 32'd0);
    check("rst_reg_we", 32'(reg_we), 32'd0);
    check("rst_reg_addr", 32'(reg_addr), 32'd0);
    check("rst_reg_wdata", 32'(reg_wdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    wait_clk(4);

    wbuf[0] = 8'hA5; wbuf[1] = 8'h3C;
    write_txn(7'h50, 8'h03, 2);

    read_txn(8'h0F, 2);

    wbuf[0] = 8'h77;
    write_txn(7'h51, 8'h05, 1);

    i2c_start();
    write_byte(8'hA0, -1, ack);
    check("mid_addr_ack", 32'(ack), 32'd0);
    write_byte(8'h07, -1, ack);
    check("mid_ptr_ack", 32'(ack), 32'd0);
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
    wbuf[0] = 8'h11;
    write_txn(7'h50, 8'h02, 1);

    i2c_start();
    write_byte(8'hA0, -1, ack);
    check("gl_addr_ack", 32'(ack), 32'd0);
    write_byte(8'h06, -1, ack);
    check("gl_ptr_ack", 32'(ack), 32'd0);
`ifdef I2C_TARGET_FILTER_EN
    exp_d = 8'hA5;
    exp_ack = 1'b0;
`else
    exp_d = slip_byte(8'hA5, 2);
    exp_ack = 1'b1;
`endif
    e.a = 4'd6;
    e.d = exp_d;
    exp_q.push_back(e);
    model_mem[6] = exp_d;
    model_ptr = 4'd7;
    write_byte(8'hA5, 2, ack);
    check("glitch_ack", 32'(ack), 32'(exp_ack));
    i2c_stop();

    i2c_start();
    write_byte(8'hA0, -1, ack);
    write_byte(8'h05, -1, ack);
    i2c_start();
    write_byte(8'hA1, -1, ack);
    check("rst_rd_ack", 32'(ack), 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      wait_clk(Q);
      if (sda_oe) begin
        seen = 1'b1;
      end else begin
        scl_m = 1'b1; wait_clk(2 * Q);
        scl_m = 1'b0;
      end
    end
    check("oe_before_reset", 32'(seen), 32'd1);
    #7 rst_n = 1'b0;
    #1;
    check("async_rst_oe", 32'(sda_oe), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_addr", 32'(reg_addr), 32'd0);
    wait_clk(4);
    model_reset();
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    rst_n = 1'b1;
    wait_clk(Q);
    write_byte(8'hA0, -1, ack);
    check("idle_no_ack", 32'(ack), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);

    for (int t = 0; t < 10; t++) begin
      case ($urandom_range(0, 2))
        0: begin
          for (int i = 0; i < 3; i++) wbuf[i] = 8'($urandom);
          write_txn(7'h50, 8'($urandom), int'($urandom_range(1, 3)));
        end
        1: read_txn(8'($urandom), int'($urandom_range(1, 3)));
        default: begin
          ra = 7'($urandom);
          if (ra == 7'h50) ra = 7'h51;
          wbuf[0] = 8'($urandom);
          write_txn(ra, 8'($urandom), 1);
        end
      endcase
    end

    wait_clk(20);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- I2C target (responder) for the 7-bit-address, register-pointer protocol our I2C master drives: START, address + R/W, register address, then write bytes or (after repeated START) read bytes, then STOP.
- Oversamples SCL/SDA on the PLL system clock and drives SDA open-drain (low only).
- Exposes a simple register-file port, so any peripheral register bank can sit behind the I2C bus.

Parameters:
- TARGET_ADDR, 7'h50, 7-bit address this target ACKs.
- ADDR_W, 4, register pointer width; the pointer uses the low ADDR_W bits of the received register-address byte.

Ports:
- clk_4MHz  input  1  system clock; SCL ≤ 100 kHz, so ≥ 40 samples per SCL period.
- rst_n  input  1  asynchronous, active-low reset.
- scl_i  input  1  raw SCL from pad.
- sda_i  input  1  raw SDA from pad.
- sda_oe  output  1  1 = pull SDA low, 0 = release.
- reg_addr  output  ADDR_W  current register pointer.
- reg_wdata  output  8  byte to write.
- reg_we  output  1  one-cycle write strobe.
- reg_rdata  input  8  read data for reg_addr; combinational, sampled by the target.
- busy  output  1  high from an address-matched START until STOP.

Behaviour:
- Reset: sda_oe=0, reg_we=0, reg_addr=0, reg_wdata=0, busy=0, FSM=IDLE, pointer=0. Reset is asynchronous and can be asserted mid-transfer; SDA is released immediately.
- Input conditioning: scl_i and sda_i each pass through a 2-FF synchronizer. Edges are detected from the synced value and its previous sample.
  - rise = SCL 0→1; fall = SCL 1→0.
  - START = SDA 1→0 while SCL=1; STOP = SDA 0→1 while SCL=1.
- Bit timing:
  - SDA is sampled on rise.
  - sda_oe changes only on fall, in the cycle after fall is detected.
  - Exceptions: START, STOP and reset release SDA at once.
- START (including repeated START) is honoured from any state: bit counter := 0, FSM → ADDR.
- STOP from any state: FSM → IDLE, sda_oe := 0, busy := 0.
- FSM states and transitions:
  - IDLE: ignore bus until START.
  - ADDR: shift 8 bits, MSB first (7 address bits + R/W).
    - On the 8th rise, if addr == TARGET_ADDR: busy := 1, go to ADDR_ACK.
    - Otherwise go to IGNORE.
  - ADDR_ACK: drive sda_oe=1 from the next fall to the following fall.
    - R/W=0: → PTR.
    - R/W=1: load shift register from reg_rdata at that fall and → RDATA, driving the MSB in the same fall.
  - PTR: shift 8 bits; pointer := byte[ADDR_W-1:0]; ACK as above; → WDATA.
  - WDATA: shift 8 bits.
    - The cycle after the 8th rise: reg_we=1 for exactly one cycle, with reg_addr=pointer and reg_wdata=byte.
    - Pointer increments mod 2^ADDR_W in the following cycle.
    - ACK, then stay in WDATA for further bytes.
  - RDATA: on each fall, sda_oe := ~shift[7], then shift left. After the 8th bit is released (sda_oe=0 on the 8th fall), → RACK.
  - RACK: sample SDA at rise.
    - 0 (ACK): pointer++ (wraps), reload from reg_rdata at the next fall, → RDATA.
    - 1 (NACK): → IGNORE, SDA released.
  - IGNORE: never drive SDA; wait for START/STOP.
- The target never ACKs a non-matching address and never drives SDA high.
- Boundaries:
  - Pointer wraps from 2^ADDR_W-1 to 0 on both writes and reads.
  - START and STOP in the same cycle cannot occur; STOP is checked first.
  - A START/STOP arriving mid-byte discards the partial byte; no reg_we is issued.
  - An address write with no data bytes issues no reg_we.

Optional Feature:
- I2C_TARGET_FILTER_EN
  - Defined: each synchronized line passes through a 3-sample majority filter before edge detection. This rejects single-cycle glitches at the cost of +2 cycles of latency on all edges.
  - Undefined: the synced signals feed edge detection directly; a one-cycle glitch on SCL counts as an edge.

Test Plan:
- Write 0x50/W, pointer 0x03, data 0xA5, 0x3C, STOP → ACK on all 3 bytes; reg_we pulses with (3, 0xA5) then (4, 0x3C); busy falls at STOP.
- Read: 0x50/W, pointer 0x0F, Sr, 0x50/R, master ACK then NACK, with reg_rdata = 0xC0|reg_addr → SDA bits show 0xCF then 0xC0 (wrap); SDA released after NACK.
- Address 0x51/W → NACK (SDA stays high on 9th clock), no reg_we, busy stays 0.
- START mid-data after 4 bits, then a full 0x50/W write to pointer 2 with data 0x11 → no reg_we from the partial byte; reg_we (2, 0x11).
- rst_n low during a read bit with sda_oe=1 → sda_oe=0 asynchronously; after release, FSM idle until next START.
- FILTER_EN build: 1-cycle SCL glitch during byte → data unaffected; without the macro, bench confirms a bit slip.
